vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the single-port video RAM between the VGA pixel-fetch path and CPU load/store requests.
- Sits between the 25 MHz display pipeline (text/graph address generation, `vidon`), the CPU bus interface and the synchronous VRAM macro.
- The VGA path has priority while active; the CPU uses the idle slots and receives a req/ack handshake.
- Includes a CPU starvation guard (optional) and out-of-range protection.

Parameters:
- ADDR_W, 15, VRAM address width (CPU and VGA).
- DATA_W, 16, VRAM word width (two 8-bit pixels/attributes).
- VRAM_DEPTH, 17400, number of valid words (4800 text + 12600 graph); addresses >= VRAM_DEPTH are out of range.
- MAX_WAIT, 64, cycles a pending CPU request may wait before a slot is stolen (guard only).
- WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk25  input  1  pixel/system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- vga_active  input  1  VGA fetch requested this cycle (driven from vidon).
- vga_address  input  ADDR_W  VGA fetch address.
- vga_rdata  output  DATA_W  fetched VGA word, registered.
- vga_miss  output  1  pulse: VGA slot lost to the CPU this cycle (guard only, else 0).
- cpu_req  input  1  CPU request, held until ack.
- cpu_we  input  1  1=write, 0=read; stable while cpu_req=1.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  DATA_W  read data, valid when cpu_ack=1.
- mem_en  output  1  VRAM access enable.
- mem_we  output  1  VRAM write enable.
- mem_addr  output  ADDR_W  VRAM address.
- mem_wdata  output  DATA_W  VRAM write data.
- mem_rdata  input  DATA_W  VRAM read data, one cycle after mem_en.

Behaviour:
- Reset: state=S_IDLE.
  - Cleared to 0: vga_rdata, cpu_rdata, cpu_ack, vga_miss, mem_en, mem_we, mem_addr, mem_wdata, wait counter.
  - Reset asserted mid-transaction aborts it with no ack and no write.
- Memory port outputs are combinational from state and inputs. Exactly one owner per cycle: VGA, CPU or none.
- VGA slot: taken whenever vga_active=1 unless the guard steals it.
  - mem_en=1, mem_we=0, mem_addr=vga_address.
  - vga_rdata loads mem_rdata on the following edge: 2-cycle address-to-vga_rdata latency.
  - When no VGA slot was issued the previous cycle, vga_rdata holds its value.
- FSM:
  - S_IDLE: CPU grant if cpu_req=1 and the slot is free (vga_active=0, or guard steal).
    - Write: mem_en=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata; go to S_ACK.
    - Read: mem_en=1, mem_we=0; go to S_RDWAIT.
    - Otherwise remain in S_IDLE.
  - S_RDWAIT: cpu_rdata<=mem_rdata; go to S_ACK. The port is free this cycle, so a VGA slot may be issued.
  - S_ACK: cpu_ack=1 for exactly this cycle; go to S_IDLE. cpu_req sampled in S_ACK is ignored. The requester drops or renews cpu_req the cycle after ack; a new request is grantable from the following S_IDLE cycle.
- Latency with a free port: write ack 1 cycle after grant; read ack 2 cycles after grant.
- Out of range (cpu_addr >= VRAM_DEPTH):
  - Write: mem_en=0, mem_we=0, still goes to S_ACK.
  - Read: mem_en=0, cpu_rdata<=0 in S_RDWAIT, normal ack.
- At most one CPU transaction in flight; no request queueing.
- Simultaneous vga_active=1 and cpu_req=1: VGA wins (except guard steal).
- mem_we never asserts in a VGA slot, S_RDWAIT or S_ACK.

Optional Feature:
- Macro VRAM_STARVE_GUARD_EN.
- Defined:
  - Wait counter increments each S_IDLE cycle with cpu_req=1 and no grant, saturating at MAX_WAIT.
  - When it equals MAX_WAIT, the next S_IDLE cycle grants the CPU even if vga_active=1. vga_miss=1 that cycle and vga_rdata holds its previous value.
  - Counter clears on any CPU grant and when cpu_req=0.
- Undefined: no counter; the CPU is granted only when vga_active=0; vga_miss tied 0.

Test Plan:
- Reset: rst_n=0 for 2 edges during a pending read -> all outputs 0, no cpu_ack, and mem_we never 1.
- Blanking write/read: vga_active=0, write 0x1234 to 0x0100 -> cpu_ack 1 cycle after grant. Read 0x0100 -> cpu_ack 2 cycles after grant with cpu_rdata=0x1234.
- VGA priority: vga_active=1 held 200 cycles with cpu_req pending, guard undefined -> mem_addr tracks vga_address each cycle with vga_rdata 2 cycles later and no cpu_ack. Drop vga_active -> ack within 2 cycles.
- Starvation guard: VRAM_STARVE_GUARD_EN, MAX_WAIT=64, vga_active=1 continuous, cpu_req write -> grant on the 65th waiting cycle with vga_miss=1 exactly once and vga_rdata unchanged that cycle.
- Out of range: write 0xBEEF to 17400 -> ack, mem_we stays 0. Read 17400 -> cpu_rdata=0, ack. Read 17399 -> normal memory data.
- Back-to-back: two reads with cpu_req reasserted the cycle after ack, vga_active toggling -> correct data per address, one ack each, never two owners in one cycle.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA pixel fetch has priority, the CPU gets idle slots via req/ack.
// Optional CPU starvation guard is compiled in with `define VRAM_STARVE_GUARD_EN.
module vram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int VRAM_DEPTH = 17400,
    parameter int MAX_WAIT   = 64,
    parameter int WAIT_W     = 8
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              vga_active,
    input  logic [ADDR_W-1:0] vga_address,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RDWAIT = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(VRAM_DEPTH);

    // The wait counter must be able to represent MAX_WAIT.
    if ((2 ** WAIT_W) <= MAX_WAIT) begin : g_wait_w_too_small_for_max_wait
    end

    state_t            state_q, state_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              vga_slot_q, vga_slot_d;
    logic              rd_oor_q, rd_oor_d;

    logic              in_range_s;
    logic              steal_s;
    logic              cpu_grant_s;
    logic              vga_grant_s;
    logic              mem_en_s, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    assign in_range_s  = ({1'b0, cpu_addr} < DEPTH_L);
    assign cpu_grant_s = (state_q == S_IDLE) && cpu_req && (!vga_active || steal_s);
    assign vga_grant_s = vga_active && !steal_s;

`ifdef VRAM_STARVE_GUARD_EN
    localparam logic [WAIT_W-1:0] WAIT_MAX_L = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q, wait_d;

    assign steal_s = (state_q == S_IDLE) && cpu_req && (wait_q == WAIT_MAX_L);

    // Count idle cycles a held CPU request goes ungranted, saturating at the limit.
    always_comb begin
        wait_d = wait_q;
        if (!cpu_req || cpu_grant_s) begin
            wait_d = '0;
        end else if ((state_q == S_IDLE) && (wait_q != WAIT_MAX_L)) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign steal_s = 1'b0;
`endif

    // Port ownership, CPU transaction sequencing and registered-output next state.
    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
        rd_oor_d    = rd_oor_q;
        vga_slot_d  = 1'b0;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;

        if (vga_grant_s) begin
            mem_en_s   = 1'b1;
            mem_addr_s = vga_address;
            vga_slot_d = 1'b1;
        end else begin
            vga_slot_d = 1'b0;
        end

        if (vga_slot_q) begin
            vga_rdata_d = mem_rdata;
        end else begin
            vga_rdata_d = vga_rdata_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cpu_grant_s) begin
                    // Out-of-range accesses still complete, but never touch the macro.
                    mem_en_s    = in_range_s;
                    mem_addr_s  = cpu_addr;
                    mem_wdata_s = cpu_wdata;
                    if (cpu_we) begin
                        mem_we_s  = in_range_s;
                        cpu_ack_d = 1'b1;
                        state_d   = S_ACK;
                    end else begin
                        rd_oor_d  = !in_range_s;
                        state_d   = S_RDWAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RDWAIT: begin
                if (rd_oor_q) begin
                    cpu_rdata_d = '0;
                end else begin
                    cpu_rdata_d = mem_rdata;
                end
                cpu_ack_d = 1'b1;
                state_d   = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            vga_slot_q  <= 1'b0;
            rd_oor_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            vga_rdata_q <= vga_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            vga_slot_q  <= vga_slot_d;
            rd_oor_q    <= rd_oor_d;
        end
    end

    // Reset forces the combinational port quiet so an aborted write can never land.
    assign mem_en    = mem_en_s & rst_n;
    assign mem_we    = mem_we_s & rst_n;
    assign mem_addr  = mem_addr_s & {ADDR_W{rst_n}};
    assign mem_wdata = mem_wdata_s & {DATA_W{rst_n}};
    assign vga_miss  = steal_s & vga_active & rst_n;
    assign cpu_ack   = cpu_ack_q & rst_n;
    assign cpu_rdata = cpu_rdata_q;
    assign vga_rdata = vga_rdata_q;

endmodule
